// File: rtl/if_stage_ctrl.sv
// Fetch-side PC generator and IF/ID pipeline register with BOOT/RUN/ERR control.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module if_stage_ctrl #(
   parameter int unsigned PC_W     = 9,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Stall,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic [31:0]     Instr_In,
   output logic [PC_W-1:0] PC,
   output logic [PC_W-1:0] IfId_PC,
   output logic [31:0]     IfId_Instr,
   output logic            IfId_Valid,
   output logic            Flush_IdEx,
   output logic            Misalign_Err,
   output logic [31:0]     Redirect_Cnt,
   output logic [31:0]     Stall_Cnt
);

   typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;

   state_t state;
   logic   misaligned;
   logic   unused_brpc_hi;

   assign misaligned     = PcSel && (BrPC[1:0] != 2'b00);
   assign unused_brpc_hi = ^BrPC[31:PC_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= BOOT;
         PC           <= '0;
         IfId_PC      <= '0;
         IfId_Instr   <= NOP_INST;
         IfId_Valid   <= 1'b0;
         Misalign_Err <= 1'b0;
      end else begin
         unique case (state)
            BOOT: begin
               IfId_Instr <= NOP_INST;
               IfId_Valid <= 1'b0;
               state      <= RUN;
            end
            RUN: begin
               if (misaligned) begin
                  Misalign_Err <= 1'b1;
                  IfId_Instr   <= NOP_INST;
                  IfId_Valid   <= 1'b0;
                  state        <= ERR;
               end else if (PcSel) begin
                  PC         <= BrPC[PC_W-1:0];
                  IfId_Instr <= NOP_INST;
                  IfId_Valid <= 1'b0;
               end else if (!Stall) begin
                  PC         <= PC + PC_W'(4);
                  IfId_PC    <= PC;
                  IfId_Instr <= Instr_In;
                  IfId_Valid <= 1'b1;
               end
            end
            ERR: begin
               IfId_Instr <= NOP_INST;
               IfId_Valid <= 1'b0;
            end
            default: state <= BOOT;
         endcase
      end
   end

   always_comb begin
      Flush_IdEx = 1'b0;
      unique case (state)
         RUN:     Flush_IdEx = PcSel;
         ERR:     Flush_IdEx = 1'b1;
         default: Flush_IdEx = 1'b0;
      endcase
   end

`ifdef PERF_CNT_EN
   logic [31:0] redirect_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         redirect_cnt <= '0;
         stall_cnt    <= '0;
      end else if (state == RUN) begin
         if (PcSel)
            redirect_cnt <= redirect_cnt + 32'd1;
         else if (Stall)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign Redirect_Cnt = redirect_cnt;
   assign Stall_Cnt    = stall_cnt;
`else
   assign Redirect_Cnt = '0;
   assign Stall_Cnt    = '0;
`endif

endmodule
